// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared constants and helpers for the multi-port register file
//             and the decode/writeback stages that connect to it.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Word width and depth shared with the decode and writeback stages
    localparam int c_rf_data_w = 32;
    localparam int c_rf_depth  = 32;

    // Sequencer states: sweep-clearing the array, then normal operation
    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    // Address width for a given depth (at least one bit)
    function automatic int rf_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_rd_port
//  Purpose  : One registered read port: zero-entry and range checks,
//             write-to-read bypass, and the output data register.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_rf_data_w,
    parameter int DEPTH    = c_rf_depth,
    parameter int AW       = rf_addr_w(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [AW-1:0]     ra,
    input  logic [DATA_W-1:0] mem_word,
    input  logic              wr_ok,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] w_next;

    // Select the read value; zero entry and out-of-range win over bypass
    always_comb begin
        w_next = mem_word;
        if (ZERO_REG && (ra == '0)) begin
            w_next = '0;
        end else if ({1'b0, ra} >= c_depth) begin
            w_next = '0;
        end else if (BYPASS && wr_ok && (wa == ra)) begin
            w_next = wd;
        end
    end

    // Output register: loads on enable, otherwise holds the last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (en) begin
            rd <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp
//  Purpose  : Parametrised register file with NUM_RD registered read ports,
//             one write port, optional bypass and hardwired-zero entry 0.
//             After reset a sequencer zeroes every entry before ready rises.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_rf_data_w,
    parameter int DEPTH    = c_rf_depth,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = rf_addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [AW-1:0]            wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*AW-1:0]     ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     ready,
    output logic                     wr_err
);

    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH-1);

    logic [0:0]        r_state;
    logic [AW-1:0]     r_cnt;
    logic              r_wr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_ready;
    logic w_wa_in_range;
    logic w_wa_zero;
    logic w_wr_ok;
    logic w_wr_err_nxt;

    assign w_ready       = (r_state == c_st_ready);
    assign w_wa_in_range = ({1'b0, wa} < c_depth);
    assign w_wa_zero     = ZERO_REG && (wa == '0);
    // Writes to the hardwired zero entry vanish quietly; only a bad
    // address or a write during the clear sweep is reported.
    assign w_wr_ok       = w_ready && we && w_wa_in_range && !w_wa_zero;
    assign w_wr_err_nxt  = we && (!w_ready || !w_wa_in_range);

    assign ready  = w_ready;
    assign wr_err = r_wr_err;

    // Clear sequencer: walk the counter through every entry, then park in READY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_clear;
            r_cnt   <= '0;
        end else if (r_state == c_st_clear) begin
            if (r_cnt == c_last) begin
                r_state <= c_st_ready;
            end else begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    // Rejected-write flag, high for exactly one cycle after the bad edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_err_nxt;
        end
    end

    // Storage: the sweep owns the array while clearing, the write port after
    always_ff @(posedge clk) begin
        if (r_state == c_st_clear) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wa] <= wd;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     w_ra;
        logic [DATA_W-1:0] w_mem_word;

        assign w_ra       = ra[gi*AW +: AW];
        // Out-of-range addresses are forced to zero inside the port
        assign w_mem_word = r_mem[w_ra];

        reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (re[gi] && w_ready),
            .ra       (w_ra),
            .mem_word (w_mem_word),
            .wr_ok    (w_wr_ok),
            .wa       (wa),
            .wd       (wd),
            .rd       (rd[gi*DATA_W +: DATA_W])
        );
    end : g_rd

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_mp
//  Purpose  : Directed bench for reg_file_mp. Three instances share stimulus:
//             A = DEPTH 32, zero reg, bypass;  B = DEPTH 32, no zero reg,
//             no bypass;  C = DEPTH 24, zero reg, bypass. All have 3 ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  re;
    logic [14:0] ra;

    logic [95:0] rd_a, rd_b, rd_c;
    logic        ready_a, ready_b, ready_c;
    logic        err_a, err_b, err_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
        .rd(rd_a), .ready(ready_a), .wr_err(err_a));

    reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
        .rd(rd_b), .ready(ready_b), .wr_err(err_b));

    reg_file_mp #(.DATA_W(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
        .rd(rd_c), .ready(ready_c), .wr_err(err_c));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  re;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] ea0, ea1, ea2;
        logic [31:0] eb0, eb1, eb2;
        logic [31:0] ec0, ec1, ec2;
        logic [2:0]  err;   // {C, B, A}
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ports(input string name, input logic [95:0] act,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        chk({name, ".rd0"}, act[31:0],  e0);
        chk({name, ".rd1"}, act[63:32], e1);
        chk({name, ".rd2"}, act[95:64], e2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we,  wa,   wd,           re,     ra0,  ra1,  ra2,   A rd0..2 | B rd0..2 | C rd0..2 | err{C,B,A}
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 3'b000, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        3'b001, 5'd5,  5'd0,  5'd0,
                     32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b000};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        3'b000, 5'd0,  5'd0,  5'd0,
                     32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b000};
        vecs[3]  = '{1'b1, 5'd7,  32'h1234,     3'b010, 5'd0,  5'd7,  5'd0,
                     32'hDEADBEEF, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h0, 3'b000};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        3'b010, 5'd0,  5'd7,  5'd0,
                     32'hDEADBEEF, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h0, 3'b000};
        vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 3'b000, 5'd0,  5'd0,  5'd0,
                     32'hDEADBEEF, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h0, 32'hDEADBEEF, 32'h1234, 32'h0, 3'b000};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        3'b001, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'h0, 32'h1234, 32'h0, 3'b000};
        vecs[7]  = '{1'b1, 5'd30, 32'hCAFEF00D, 3'b000, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'h0, 32'h1234, 32'h0, 3'b100};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        3'b100, 5'd0,  5'd0,  5'd30,
                     32'h0, 32'h1234, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h1234, 32'hCAFEF00D, 32'h0, 32'h1234, 32'h0, 3'b000};
        vecs[9]  = '{1'b1, 5'd9,  32'h99,       3'b111, 5'd3,  5'd3,  5'd9,
                     32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h99, 3'b000};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        3'b111, 5'd3,  5'd3,  5'd9,
                     32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 3'b000};
        vecs[11] = '{1'b1, 5'd24, 32'h55AA55AA, 3'b000, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 3'b100};
        vecs[12] = '{1'b1, 5'd23, 32'hA5A5A5A5, 3'b000, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 32'h99, 3'b000};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        3'b011, 5'd23, 5'd24, 5'd0,
                     32'hA5A5A5A5, 32'h55AA55AA, 32'h99, 32'hA5A5A5A5, 32'h55AA55AA, 32'h99,
                     32'hA5A5A5A5, 32'h0, 32'h99, 3'b000};
        vecs[14] = '{1'b1, 5'd0,  32'h77,       3'b001, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h55AA55AA, 32'h99, 32'hFFFFFFFF, 32'h55AA55AA, 32'h99,
                     32'h0, 32'h0, 32'h99, 3'b000};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        3'b001, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h55AA55AA, 32'h99, 32'h77, 32'h55AA55AA, 32'h99,
                     32'h0, 32'h0, 32'h99, 3'b000};

        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; re = '0; ra = '0;
        repeat (3) step();

        // Reset state
        chk_ports("reset a", rd_a, 32'h0, 32'h0, 32'h0);
        chk_ports("reset c", rd_c, 32'h0, 32'h0, 32'h0);
        chk("reset ready_a", 32'(ready_a), 32'h0);
        chk("reset wr_err_a", 32'(err_a), 32'h0);

        // First sweep: a write during CLEAR is reported, then abort at edge 10
        rst_n = 1'b1;
        we    = 1'b1;
        wa    = 5'd3;
        wd    = 32'h1111;
        step();
        chk("clear-we wr_err_a", 32'(err_a), 32'h1);
        chk("clear-we wr_err_b", 32'(err_b), 32'h1);
        chk("clear-we wr_err_c", 32'(err_c), 32'h1);
        we = 1'b0;
        step();
        chk("clear-we pulse end a", 32'(err_a), 32'h0);
        repeat (8) step();
        chk("edge10 ready_a", 32'(ready_a), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid-reset ready_a", 32'(ready_a), 32'h0);
        step();
        rst_n = 1'b1;

        // Full sweep from zero: DEPTH edges to ready
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 23) chk("edge23 ready_c", 32'(ready_c), 32'h0);
            if (k == 24) chk("edge24 ready_c", 32'(ready_c), 32'h1);
            if (k == 31) begin
                chk("edge31 ready_a", 32'(ready_a), 32'h0);
                chk("edge31 ready_b", 32'(ready_b), 32'h0);
            end
            if (k == 32) begin
                chk("edge32 ready_a", 32'(ready_a), 32'h1);
                chk("edge32 ready_b", 32'(ready_b), 32'h1);
            end
        end

        // Every entry reads back zero after the sweep
        for (int i = 0; i < 32; i++) begin
            re = 3'b111;
            ra = {5'(i), 5'(i), 5'(i)};
            step();
            chk_ports($sformatf("sweep%0d a", i), rd_a, 32'h0, 32'h0, 32'h0);
            chk_ports($sformatf("sweep%0d b", i), rd_b, 32'h0, 32'h0, 32'h0);
            chk_ports($sformatf("sweep%0d c", i), rd_c, 32'h0, 32'h0, 32'h0);
        end

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            we = vecs[v].we;
            wa = vecs[v].wa;
            wd = vecs[v].wd;
            re = vecs[v].re;
            ra = {vecs[v].ra2, vecs[v].ra1, vecs[v].ra0};
            step();
            chk_ports($sformatf("v%0d a", v), rd_a, vecs[v].ea0, vecs[v].ea1, vecs[v].ea2);
            chk_ports($sformatf("v%0d b", v), rd_b, vecs[v].eb0, vecs[v].eb1, vecs[v].eb2);
            chk_ports($sformatf("v%0d c", v), rd_c, vecs[v].ec0, vecs[v].ec1, vecs[v].ec2);
            chk($sformatf("v%0d wr_err_a", v), 32'(err_a), 32'(vecs[v].err[0]));
            chk($sformatf("v%0d wr_err_b", v), 32'(err_b), 32'(vecs[v].err[1]));
            chk($sformatf("v%0d wr_err_c", v), 32'(err_c), 32'(vecs[v].err[2]));
        end

        // ready is permanent once reached
        we = 1'b0; re = '0;
        repeat (3) step();
        chk("ready_a sticky", 32'(ready_a), 32'h1);
        chk("ready_c sticky", 32'(ready_c), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
